// File: rtl/fa4_serial_add_ctrl.sv
// Nibble-serial W-bit adder/subtractor built around one shared 4-bit ripple adder.
// Operands are captured on accept and consumed LS nibble first; the result is held until accepted.

module fa4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < 4; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co = c[4];
endmodule

module fa4_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 sub,
  input  logic                 cin,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 ovf,
  output logic                 busy
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_next;
  logic [W-1:0]  a_sh, b_sh, sum_r;
  logic [W+3:0]  sum_cat;
  logic [IW-1:0] index;
  logic          carry, cout_r, ovf_r;
  logic [3:0]    nib_s;
  logic          nib_co;

  fa4 u_fa4 (
    .a  (a_sh[3:0]),
    .b  (b_sh[3:0]),
    .ci (carry),
    .s  (nib_s),
    .co (nib_co)
  );

  // New nibble enters the result from the top; after NIBBLES shifts the word is fully replaced.
  assign sum_cat = {nib_s, sum_r};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (index == LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      index  <= '0;
    end else if (state == IDLE && in_valid) begin
      a_sh  <= a;
      b_sh  <= sub ? ~b : b;
      carry <= sub | cin;
      index <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 4;
      b_sh   <= b_sh >> 4;
      sum_r  <= sum_cat[W+3:4];
      carry  <= nib_co;
      cout_r <= nib_co;
      // Only the final nibble's value survives, giving carry-into-MSB xor carry-out.
      ovf_r  <= nib_s[3] ^ a_sh[3] ^ b_sh[3] ^ nib_co;
      index  <= index + 1'b1;
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;
endmodule

// File: tb/tb_fa4_serial_add_ctrl.sv
// Self-checking bench for fa4_serial_add_ctrl: directed vector table, multi-cycle corner
// sequences and a randomised scoreboard run against a behavioural W-bit model.

module tb_fa4_serial_add_ctrl;
  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk;
  logic         rst_n, in_valid, in_ready, sub, cin;
  logic         out_valid, out_ready, cout, ovf, busy;
  logic [W-1:0] a, b, sum;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[5];

  fa4_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sub       (sub),
    .cin       (cin),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic subv, input logic cinv);
    exp_t         r;
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         c0;
    bb     = subv ? ~bv : bv;
    c0     = subv ? 1'b1 : cinv;
    full   = {1'b0, av} + {1'b0, bb} + {{W{1'b0}}, c0};
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (av[W-1] & bb[W-1] & ~r.sum[W-1]) | (~av[W-1] & ~bb[W-1] & r.sum[W-1]);
    return r;
  endfunction

  // Waits for in_ready, performs one accept, then scrambles the operand inputs.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic subv, input logic cinv,
                               input exp_t e, input bit push);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", in_ready, 1);
      return;
    end
    a = av; b = bv; sub = subv; cin = cinv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    if (push) sb.push_back(e);
  endtask

  // Waits for out_valid, stalls, then compares the head of the scoreboard at handshake.
  task automatic takeResult(input int stall, output int lat);
    exp_t e;
    lat = 0;
    checkOutput("run_busy", busy, 1);
    checkOutput("run_in_ready", in_ready, 0);
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    if (!out_valid) begin
      checkOutput("result_timeout", out_valid, 1);
      return;
    end
    repeat (stall) tick();
    if (sb.size() == 0) begin
      checkOutput("sb_underflow", 0, 1);
    end else begin
      e = sb.pop_front();
      checkOutput("sum", sum, e.sum);
      checkOutput("cout", cout, e.cout);
      checkOutput("ovf", ovf, e.ovf);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("valid_drop", out_valid, 0);
    checkOutput("idle_ready", in_ready, 1);
  endtask

  initial begin
    exp_t         e;
    int           lat;
    logic [W-1:0] ra, rb;
    logic         rs, rc;

    vecs[0] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0};
    vecs[3] = '{16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (3) tick();
    rst_n = 1'b1; in_valid = 1'b0;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_sum", sum, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_cout", cout, 0);
    checkOutput("rst_ovf", ovf, 0);

    for (int i = 0; i < 5; i++) begin
      e.sum = vecs[i].sum; e.cout = vecs[i].cout; e.ovf = vecs[i].ovf;
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, e, 1'b1);
      takeResult(0, lat);
      checkOutput("latency", W'(lat), W'(NIBBLES));
    end

    // Backpressure: result held through a 5-cycle stall while a new request waits.
    e.sum = 16'h1234; e.cout = 1'b0; e.ovf = 1'b0;
    applyStimulus(16'h1230, 16'h0004, 1'b0, 1'b0, e, 1'b1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    a = 16'h0010; b = 16'h0020; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_valid", out_valid, 1);
      checkOutput("stall_sum", sum, 16'h1234);
      checkOutput("stall_in_ready", in_ready, 0);
      tick();
    end
    e = sb.pop_front();
    checkOutput("bp_sum", sum, e.sum);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("bp_idle_ready", in_ready, 1);
    checkOutput("bp_valid_drop", out_valid, 0);
    checkOutput("bp_sum_kept", sum, 16'h1234);
    tick();
    in_valid = 1'b0;
    checkOutput("bp_accept_busy", busy, 1);
    e.sum = 16'h0030; e.cout = 1'b0; e.ovf = 1'b0;
    sb.push_back(e);
    takeResult(0, lat);

    // Abort: reset in the second RUN cycle, then confirm no stale carry survives.
    e.sum = '0; e.cout = 1'b0; e.ovf = 1'b0;
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b1, e, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("abort_in_ready", in_ready, 1);
    checkOutput("abort_out_valid", out_valid, 0);
    checkOutput("abort_busy", busy, 0);
    e.sum = 16'h0002; e.cout = 1'b0; e.ovf = 1'b0;
    applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0, e, 1'b1);
    takeResult(0, lat);

    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom); rc = 1'($urandom);
      if (i % 10 == 0) rb = ~ra;
      applyStimulus(ra, rb, rs, rc, model(ra, rb, rs, rc), 1'b1);
      takeResult(int'($urandom_range(0, 3)), lat);
    end

    checkOutput("sb_empty", W'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
